// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: opcodes, FSM states,
// datapath mux selects and the per-state control word decode.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JALR_ADR, S_JAL, S_LUI, S_HALT
    } state_t;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       fetch;
        logic       jal_pc;
        logic       branch;
        logic       reg_write;
        logic       mem_write;
        logic       halted;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // Moore control word for a state; anything not named stays 0.
    function automatic ctrl_t ctrl_decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.fetch      = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALURES;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMADR, S_JALR_ADR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_RD2;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_RD2;
                c.alu_op    = ALUOP_SUB;
                c.branch    = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
                c.jal_pc    = 1'b1;
            end
            S_LUI: begin
                c.result_src = RES_IMM;
                c.reg_write  = 1'b1;
            end
            S_HALT: begin
                c.halted = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/imm_src_dec.sv
// Immediate-format decode from the opcode; purely combinational so the
// extender sees the right format in every state, including reset.
module imm_src_dec
    import riscv_ctrl_pkg::*;
#(
    parameter int IMMSRC_W = 3
) (
    input  logic [6:0]          op,
    output logic [IMMSRC_W-1:0] imm_src
);

    // Opcode to immediate format; R-type and unknown ops fall back to I.
    always_comb begin
        imm_src = '0;
        case (op)
            OP_LOAD, OP_ITYPE, OP_JALR: imm_src = IMMSRC_W'(IMM_I);
            OP_STORE:                   imm_src = IMMSRC_W'(IMM_S);
            OP_BRANCH:                  imm_src = IMMSRC_W'(IMM_B);
            OP_JAL:                     imm_src = IMMSRC_W'(IMM_J);
            OP_LUI, OP_AUIPC:           imm_src = IMMSRC_W'(IMM_U);
            default:                    imm_src = IMMSRC_W'(IMM_I);
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I control FSM with memory handshake, watchdog and instret.
// Define MC_CTRL_ILLEGAL_TRAP_EN to halt on an illegal opcode instead of skipping it.
module mc_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 2,
    parameter int IMMSRC_W    = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          op,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                adr_src,
    output logic                ir_write,
    output logic                pc_update,
    output logic                branch,
    output logic                reg_write,
    output logic                mem_write,
    output logic [1:0]          result_src,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [IMMSRC_W-1:0] imm_src,
    output logic [CNT_W-1:0]    instret,
    output logic                halted
);

    localparam int WD_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int WD_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    state_t            state_r;
    state_t            state_nxt_s;
    ctrl_t             ctrl_r;
    logic [WD_W-1:0]   wait_cnt_r;
    logic [CNT_W-1:0]  instret_r;
    logic              wd_expire_s;
    logic              retire_s;
    logic              wait_entry_s;

    // The last allowed waiting cycle only expires if ready is still low.
    assign wd_expire_s  = (MEM_TIMEOUT > 0) && !mem_ready && (wait_cnt_r == WD_W'(WD_LAST));
    assign retire_s     = (state_r == S_MEMWB) || (state_r == S_ALUWB) || (state_r == S_BRANCH) ||
                          (state_r == S_LUI) || ((state_r == S_MEMWRITE) && mem_ready);
    assign wait_entry_s = (state_nxt_s != state_r) &&
                          ((state_nxt_s == S_FETCH) || (state_nxt_s == S_MEMREAD) ||
                           (state_nxt_s == S_MEMWRITE));

    // Next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: state_nxt_s = S_FETCH;
            S_FETCH: begin
                if (mem_ready)        state_nxt_s = S_DECODE;
                else if (wd_expire_s) state_nxt_s = S_HALT;
                else                  state_nxt_s = S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_nxt_s = S_MEMADR;
                    OP_RTYPE:          state_nxt_s = S_EXEC_R;
                    OP_ITYPE:          state_nxt_s = S_EXEC_I;
                    OP_BRANCH:         state_nxt_s = S_BRANCH;
                    OP_JAL:            state_nxt_s = S_JAL;
                    OP_JALR:           state_nxt_s = S_JALR_ADR;
                    OP_LUI:            state_nxt_s = S_LUI;
                    OP_AUIPC:          state_nxt_s = S_ALUWB;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    default:           state_nxt_s = S_HALT;
`else
                    default:           state_nxt_s = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                if (op[5]) state_nxt_s = S_MEMWRITE;
                else       state_nxt_s = S_MEMREAD;
            end
            S_MEMREAD: begin
                if (mem_ready)        state_nxt_s = S_MEMWB;
                else if (wd_expire_s) state_nxt_s = S_HALT;
                else                  state_nxt_s = S_MEMREAD;
            end
            S_MEMWRITE: begin
                if (mem_ready)        state_nxt_s = S_FETCH;
                else if (wd_expire_s) state_nxt_s = S_HALT;
                else                  state_nxt_s = S_MEMWRITE;
            end
            S_MEMWB, S_ALUWB, S_BRANCH, S_LUI: state_nxt_s = S_FETCH;
            S_EXEC_R, S_EXEC_I, S_JAL:         state_nxt_s = S_ALUWB;
            S_JALR_ADR:                        state_nxt_s = S_JAL;
            S_HALT:                            state_nxt_s = S_HALT;
            default:                           state_nxt_s = S_HALT;
        endcase
    end

    // State register; control word is decoded from the next state so it is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            ctrl_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            ctrl_r  <= ctrl_decode(state_nxt_s);
        end
    end

    // Memory watchdog and retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= '0;
            instret_r  <= '0;
        end else begin
            if (wait_entry_s) begin
                wait_cnt_r <= '0;
            end else if (ctrl_r.mem_req && !mem_ready) begin
                wait_cnt_r <= wait_cnt_r + WD_W'(1);
            end
            if (retire_s) begin
                instret_r <= instret_r + CNT_W'(1);
            end
        end
    end

    imm_src_dec #(
        .IMMSRC_W (IMMSRC_W)
    ) u_imm_src_dec (
        .op      (op),
        .imm_src (imm_src)
    );

    // IR and PC load during fetch are qualified by the handshake completing.
    assign mem_req    = ctrl_r.mem_req;
    assign adr_src    = ctrl_r.adr_src;
    assign ir_write   = ctrl_r.fetch & mem_ready;
    assign pc_update  = ctrl_r.jal_pc | (ctrl_r.fetch & mem_ready);
    assign branch     = ctrl_r.branch;
    assign reg_write  = ctrl_r.reg_write;
    assign mem_write  = ctrl_r.mem_write;
    assign result_src = ctrl_r.result_src;
    assign alu_src_a  = ctrl_r.alu_src_a;
    assign alu_src_b  = ctrl_r.alu_src_b;
    assign alu_op     = ALUOP_W'(ctrl_r.alu_op);
    assign instret    = instret_r;
    assign halted     = ctrl_r.halted;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm; state is observed through the packed output vector.
module tb_mc_ctrl_fsm;

    // {mem_req,adr_src,ir_write,pc_update,branch,reg_write,mem_write,res,src_a,src_b,alu_op,halted}
    localparam logic [15:0] E_IDLE      = 16'b0000000_00_00_00_00_0;
    localparam logic [15:0] E_FETCH_RDY = 16'b1011000_10_00_10_00_0;
    localparam logic [15:0] E_FETCH_W   = 16'b1000000_10_00_10_00_0;
    localparam logic [15:0] E_DECODE    = 16'b0000000_00_01_01_00_0;
    localparam logic [15:0] E_MEMADR    = 16'b0000000_00_10_01_00_0;
    localparam logic [15:0] E_MEMREAD   = 16'b1100000_00_00_00_00_0;
    localparam logic [15:0] E_MEMWRITE  = 16'b1100001_00_00_00_00_0;
    localparam logic [15:0] E_MEMWB     = 16'b0000010_01_00_00_00_0;
    localparam logic [15:0] E_EXEC_R    = 16'b0000000_00_10_00_10_0;
    localparam logic [15:0] E_EXEC_I    = 16'b0000000_00_10_01_10_0;
    localparam logic [15:0] E_ALUWB     = 16'b0000010_00_00_00_00_0;
    localparam logic [15:0] E_BRANCH    = 16'b0000100_00_10_00_01_0;
    localparam logic [15:0] E_JALR_ADR  = 16'b0000000_00_10_01_00_0;
    localparam logic [15:0] E_JAL       = 16'b0001000_00_01_10_00_0;
    localparam logic [15:0] E_LUI       = 16'b0000010_11_00_00_00_0;
    localparam logic [15:0] E_HALT      = 16'b0000000_00_00_00_00_1;

    logic        clk;
    logic        rst_n;
    logic [6:0]  op;
    logic        mem_ready;
    logic        mem_req, adr_src, ir_write, pc_update, branch, reg_write, mem_write, halted;
    logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0]  imm_src;
    logic [31:0] instret;
    logic [31:0] exp_instret;
    int          checks;
    int          errors;

    mc_ctrl_fsm #(
        .ALUOP_W(2), .IMMSRC_W(3), .MEM_TIMEOUT(4), .CNT_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req), .adr_src(adr_src), .ir_write(ir_write), .pc_update(pc_update),
        .branch(branch), .reg_write(reg_write), .mem_write(mem_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .imm_src(imm_src), .instret(instret), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] obs();
        return {mem_req, adr_src, ir_write, pc_update, branch, reg_write, mem_write,
                result_src, alu_src_a, alu_src_b, alu_op, halted};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; op = 7'b0100011; mem_ready = 1'b0; exp_instret = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs() !== E_IDLE) begin errors++; $display("FAIL reset_outs got %b want %b", obs(), E_IDLE); end
        checks++;
        if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret got %0d want 0", instret); end
        checks++;
        if (imm_src !== 3'b001) begin errors++; $display("FAIL reset_imm_src got %b want 001", imm_src); end
        @(negedge clk);
        rst_n = 1'b1; op = 7'b0110011;
    endtask

    task automatic test_add();
        logic [15:0] exp_v [5] = '{E_FETCH_RDY, E_DECODE, E_EXEC_R, E_ALUWB, E_FETCH_RDY};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1; mem_ready = 1'b1; #1;
            checks++;
            if (obs() !== exp_v[i]) begin errors++; $display("FAIL add step%0d got %b want %b", i, obs(), exp_v[i]); end
            if (i == 3) begin
                checks++;
                if (instret !== 32'd0) begin errors++; $display("FAIL add_instret_early got %0d want 0", instret); end
            end
        end
        exp_instret++;
        checks++;
        if (instret !== exp_instret) begin errors++; $display("FAIL add_instret got %0d want %0d", instret, exp_instret); end
    endtask

    task automatic test_lw();
        logic [15:0] exp_v [8] = '{E_DECODE, E_MEMADR, E_MEMREAD, E_MEMREAD, E_MEMREAD, E_MEMREAD, E_MEMWB, E_FETCH_RDY};
        logic        rdy_v [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        op = 7'b0000011;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1; mem_ready = rdy_v[i]; #1;
            checks++;
            if (obs() !== exp_v[i]) begin errors++; $display("FAIL lw step%0d got %b want %b", i, obs(), exp_v[i]); end
        end
        exp_instret++;
        checks++;
        if (instret !== exp_instret) begin errors++; $display("FAIL lw_instret got %0d want %0d", instret, exp_instret); end
    endtask

    task automatic test_sw();
        logic [15:0] exp_v [6] = '{E_DECODE, E_MEMADR, E_MEMWRITE, E_MEMWRITE, E_MEMWRITE, E_FETCH_RDY};
        logic        rdy_v [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        op = 7'b0100011;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1; mem_ready = rdy_v[i]; #1;
            checks++;
            if (obs() !== exp_v[i]) begin errors++; $display("FAIL sw step%0d got %b want %b", i, obs(), exp_v[i]); end
            if (i == 0) begin
                checks++;
                if (imm_src !== 3'b001) begin errors++; $display("FAIL sw_imm_src got %b want 001", imm_src); end
            end
        end
        exp_instret++;
        checks++;
        if (instret !== exp_instret) begin errors++; $display("FAIL sw_instret got %0d want %0d", instret, exp_instret); end
    endtask

    task automatic test_jalr();
        logic [15:0] exp_v [5] = '{E_DECODE, E_JALR_ADR, E_JAL, E_ALUWB, E_FETCH_RDY};
        op = 7'b1100111;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1; mem_ready = 1'b1; #1;
            checks++;
            if (obs() !== exp_v[i]) begin errors++; $display("FAIL jalr step%0d got %b want %b", i, obs(), exp_v[i]); end
        end
        exp_instret++;
        checks++;
        if (instret !== exp_instret) begin errors++; $display("FAIL jalr_instret got %0d want %0d", instret, exp_instret); end
    endtask

    task automatic test_auipc();
        logic [15:0] exp_v [3] = '{E_DECODE, E_ALUWB, E_FETCH_RDY};
        op = 7'b0010111;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; mem_ready = 1'b1; #1;
            checks++;
            if (obs() !== exp_v[i]) begin errors++; $display("FAIL auipc step%0d got %b want %b", i, obs(), exp_v[i]); end
            if (i == 0) begin
                checks++;
                if (imm_src !== 3'b100) begin errors++; $display("FAIL auipc_imm_src got %b want 100", imm_src); end
            end
        end
        exp_instret++;
        checks++;
        if (instret !== exp_instret) begin errors++; $display("FAIL auipc_instret got %0d want %0d", instret, exp_instret); end
    endtask

    task automatic test_branch_lui();
        logic [15:0] exp_v [6] = '{E_DECODE, E_BRANCH, E_FETCH_RDY, E_DECODE, E_LUI, E_FETCH_RDY};
        logic [2:0]  imm_v [6] = '{3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b100};
        op = 7'b1100011;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1; mem_ready = 1'b1; #1;
            checks++;
            if (obs() !== exp_v[i]) begin errors++; $display("FAIL br_lui step%0d got %b want %b", i, obs(), exp_v[i]); end
            checks++;
            if (imm_src !== imm_v[i]) begin errors++; $display("FAIL br_lui_imm step%0d got %b want %b", i, imm_src, imm_v[i]); end
            if (i == 2) op = 7'b0110111;
        end
        exp_instret = exp_instret + 32'd2;
        checks++;
        if (instret !== exp_instret) begin errors++; $display("FAIL br_lui_instret got %0d want %0d", instret, exp_instret); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_v [8] = '{E_DECODE, E_EXEC_I, E_ALUWB, E_FETCH_RDY, E_DECODE, E_EXEC_R, E_ALUWB, E_FETCH_RDY};
        op = 7'b0010011;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1; mem_ready = 1'b1; #1;
            checks++;
            if (obs() !== exp_v[i]) begin errors++; $display("FAIL b2b step%0d got %b want %b", i, obs(), exp_v[i]); end
            if (i == 3) op = 7'b0110011;
        end
        exp_instret = exp_instret + 32'd2;
        checks++;
        if (instret !== exp_instret) begin errors++; $display("FAIL b2b_instret got %0d want %0d", instret, exp_instret); end
    endtask

    task automatic test_illegal();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        logic [15:0] exp_v [3] = '{E_DECODE, E_HALT, E_HALT};
`else
        logic [15:0] exp_v [3] = '{E_DECODE, E_FETCH_RDY, E_DECODE};
`endif
        op = 7'b1111111;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; mem_ready = 1'b1; #1;
            checks++;
            if (obs() !== exp_v[i]) begin errors++; $display("FAIL illegal step%0d got %b want %b", i, obs(), exp_v[i]); end
        end
        checks++;
        if (instret !== exp_instret) begin errors++; $display("FAIL illegal_instret got %0d want %0d", instret, exp_instret); end
    endtask

    task automatic test_timeout();
        logic [15:0] exp_v [6] = '{E_FETCH_W, E_FETCH_W, E_FETCH_W, E_FETCH_W, E_HALT, E_HALT};
        logic        rdy_v [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        rst_n = 1'b0; mem_ready = 1'b0; op = 7'b0110011;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        exp_instret = 32'd0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1; mem_ready = rdy_v[i]; #1;
            checks++;
            if (obs() !== exp_v[i]) begin errors++; $display("FAIL timeout step%0d got %b want %b", i, obs(), exp_v[i]); end
        end
        checks++;
        if (instret !== exp_instret) begin errors++; $display("FAIL timeout_instret got %0d want %0d", instret, exp_instret); end
    endtask

    task automatic test_reset_mid_access();
        rst_n = 1'b0; mem_ready = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #2;
        checks++;
        if (obs() !== E_FETCH_W) begin errors++; $display("FAIL midrst_fetch got %b want %b", obs(), E_FETCH_W); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== E_IDLE) begin errors++; $display("FAIL midrst_outs got %b want %b", obs(), E_IDLE); end
        checks++;
        if (instret !== 32'd0) begin errors++; $display("FAIL midrst_instret got %0d want 0", instret); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add();
        test_lw();
        test_sw();
        test_jalr();
        test_auipc();
        test_branch_lui();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
